iir_section_sched: RTL and testbench

- Time-multiplexed controller for the cascaded biquad IIR datapath.
- Sequences one shared 16x16 multiplier and one 36-bit accumulator across all taps of N_SECTIONS direct-form-I biquads.
- Applies >>>14 truncation and 16-bit saturation at each section output.
- Holds the coefficient and history storage, and sits between the sample source and sink.

---
 rtl/iir_section_sched.sv | 182 ++++++++++++++++++
 tb/tb_iir_section_sched.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_section_sched.sv
// Time-multiplexed scheduler for a cascade of direct-form-I biquads: one shared
// 16x16 multiplier and a 36-bit accumulator step through five taps per section.
module iir_section_sched #(
  parameter int N_SECTIONS = 4,
  parameter int ADDR_W     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [15:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [15:0]       out_data,
  input  logic                     cfg_we,
  input  logic        [ADDR_W-1:0] cfg_addr,
  input  logic signed [15:0]       cfg_data,
  output logic                     cfg_err,
  input  logic                     clr_hist,
  output logic                     busy
);

  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 36;
  localparam int SEC_W  = (N_SECTIONS > 1) ? $clog2(N_SECTIONS) : 1;
  localparam int N_COEF_ENTRIES = 2 ** ADDR_W;
  localparam int N_HIST_ENTRIES = 2 ** SEC_W;
  localparam logic [ADDR_W:0] N_COEF = (ADDR_W + 1)'(5 * N_SECTIONS);

  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

  state_t                    r_state;
  logic        [SEC_W-1:0]   r_sec;
  logic        [2:0]         r_tap;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_x;
  logic signed [COEF_W-1:0]  r_coef [N_COEF_ENTRIES];
  logic signed [DATA_W-1:0]  r_x1   [N_HIST_ENTRIES];
  logic signed [DATA_W-1:0]  r_x2   [N_HIST_ENTRIES];
  logic signed [DATA_W-1:0]  r_y1   [N_HIST_ENTRIES];
  logic signed [DATA_W-1:0]  r_y2   [N_HIST_ENTRIES];
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_out_data;
  logic                      r_cfg_err;
  logic                      r_busy;

  logic        [ADDR_W-1:0]  w_cidx;
  logic signed [COEF_W-1:0]  w_coef;
  logic signed [DATA_W-1:0]  w_opd;
  logic signed [31:0]        w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [DATA_W-1:0]  w_y;
  logic                      w_idle;
  logic                      w_addr_bad;
  logic                      w_cfg_ok;
  logic                      w_err;

  // Truncating >>>14 (toward -inf) followed by clamp to the 16-bit range.
  function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> 14;
    if (s > 36'sd32767)       return 16'sd32767;
    else if (s < -36'sd32768) return -16'sd32768;
    else                      return s[DATA_W-1:0];
  endfunction

  assign w_cidx     = ADDR_W'(32'(r_sec) * 5 + 32'(r_tap));
  assign w_coef     = r_coef[w_cidx];
  assign w_prod     = w_coef * w_opd;
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_y        = sat_shift(r_acc);

  always_comb begin
    w_opd = r_x;
    case (r_tap)
      3'd1:    w_opd = r_x1[r_sec];
      3'd2:    w_opd = r_x2[r_sec];
      3'd3:    w_opd = r_y1[r_sec];
      3'd4:    w_opd = r_y2[r_sec];
      default: w_opd = r_x;
    endcase
  end

  assign w_idle     = (r_state == IDLE);
  assign w_addr_bad = ({1'b0, cfg_addr} >= N_COEF);
  assign w_cfg_ok   = cfg_we && w_idle && !w_addr_bad;
  assign w_err      = (cfg_we && (!w_idle || w_addr_bad)) || (clr_hist && !w_idle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sec       <= '0;
      r_tap       <= '0;
      r_acc       <= '0;
      r_x         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_cfg_err   <= 1'b0;
      r_busy      <= 1'b0;
      // Default coefficients make every section a unity-gain passthrough.
      for (int i = 0; i < N_COEF_ENTRIES; i++) begin
        r_coef[ADDR_W'(i)] <= ((i % 5 == 0) && (i < 5 * N_SECTIONS)) ? 16'sd16384 : 16'sd0;
      end
      for (int i = 0; i < N_HIST_ENTRIES; i++) begin
        r_x1[SEC_W'(i)] <= '0;
        r_x2[SEC_W'(i)] <= '0;
        r_y1[SEC_W'(i)] <= '0;
        r_y2[SEC_W'(i)] <= '0;
      end
    end else begin
      r_cfg_err <= w_err;
      case (r_state)
        IDLE: begin
          if (w_cfg_ok) r_coef[cfg_addr] <= cfg_data;
          if (clr_hist) begin
            for (int i = 0; i < N_HIST_ENTRIES; i++) begin
              r_x1[SEC_W'(i)] <= '0;
              r_x2[SEC_W'(i)] <= '0;
              r_y1[SEC_W'(i)] <= '0;
              r_y2[SEC_W'(i)] <= '0;
            end
          end
          if (in_valid) begin
            r_x        <= in_data;
            r_acc      <= '0;
            r_sec      <= '0;
            r_tap      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= MAC;
          end
        end
        MAC: begin
          // Feed-forward taps add, feedback taps (a1, a2) subtract.
          if (r_tap < 3'd3) r_acc <= r_acc + w_prod_ext;
          else              r_acc <= r_acc - w_prod_ext;
          if (r_tap == 3'd4) begin
            r_tap   <= '0;
            r_state <= WB;
          end else begin
            r_tap <= r_tap + 3'd1;
          end
        end
        WB: begin
          r_x2[r_sec] <= r_x1[r_sec];
          r_x1[r_sec] <= r_x;
          r_y2[r_sec] <= r_y1[r_sec];
          r_y1[r_sec] <= w_y;
          r_x         <= w_y;
          r_acc       <= '0;
          if (r_sec == SEC_W'(N_SECTIONS - 1)) begin
            r_out_data  <= w_y;
            r_out_valid <= 1'b1;
            r_state     <= OUT;
          end else begin
            r_sec   <= r_sec + SEC_W'(1);
            r_state <= MAC;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign cfg_err   = r_cfg_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_iir_section_sched.sv
// Bench for iir_section_sched: directed and random samples checked against a
// plain-arithmetic biquad cascade model.
module tb_iir_section_sched;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int EXP_LAT = 6 * N + 1;  // cycle of out_valid, handshake cycle numbered 1
  localparam int PERIOD  = 6 * N + 2;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [15:0]   in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [15:0]   out_data;
  logic                 cfg_we;
  logic        [AW-1:0] cfg_addr;
  logic signed [15:0]   cfg_data;
  logic                 cfg_err;
  logic                 clr_hist;
  logic                 busy;

  int n_checks = 0;
  int n_fail   = 0;

  int m_coef [5*N];
  int m_x1 [N];
  int m_x2 [N];
  int m_y1 [N];
  int m_y2 [N];

  iir_section_sched #(.N_SECTIONS(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
    .clr_hist(clr_hist), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void m_clear();
    for (int k = 0; k < N; k++) begin
      m_x1[k] = 0; m_x2[k] = 0; m_y1[k] = 0; m_y2[k] = 0;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 5*N; i++) m_coef[i] = (i % 5 == 0) ? 16384 : 0;
    m_clear();
  endfunction

  // y = (b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2) / 2^14 rounded to -inf, clamped.
  function automatic int m_step(input int x);
    int xi;
    longint acc;
    longint s;
    int y;
    xi = x;
    for (int k = 0; k < N; k++) begin
      acc = longint'(m_coef[5*k])   * xi      + longint'(m_coef[5*k+1]) * m_x1[k]
          + longint'(m_coef[5*k+2]) * m_x2[k] - longint'(m_coef[5*k+3]) * m_y1[k]
          - longint'(m_coef[5*k+4]) * m_y2[k];
      s = acc >>> 14;
      y = (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
      m_x2[k] = m_x1[k]; m_x1[k] = xi;
      m_y2[k] = m_y1[k]; m_y1[k] = y;
      xi = y;
    end
    return xi;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic signed [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic clear_hist();
    @(negedge clk);
    clr_hist = 1'b1;
    @(negedge clk);
    clr_hist = 1'b0;
    m_clear();
  endtask

  // One sample transaction from IDLE with optional same-cycle clear/config.
  task automatic xact(input logic signed [15:0] x, input logic clr, input logic we,
                      input logic [AW-1:0] a, input logic signed [15:0] d,
                      output logic signed [15:0] y, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_data = x; clr_hist = clr;
    cfg_we = we; cfg_addr = a; cfg_data = d; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clr_hist = 1'b0; cfg_we = 1'b0;
    lat = 1;
    y = 'x;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
    else begin
      y = out_data;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (cfg_err !== 1'b0)   begin n_fail++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_passthrough();
    logic signed [15:0] y, e, x;
    int lat;
    xact(16'sd1000, 1'b0, 1'b0, '0, '0, y, lat);
    e = 16'(m_step(1000));
    n_checks++; if (y !== 16'sd1000) begin n_fail++; $display("FAIL pass_pos got=%0d exp=1000", y); end
    n_checks++; if (lat !== EXP_LAT) begin n_fail++; $display("FAIL pass_latency got=%0d exp=%0d", lat, EXP_LAT); end
    xact(-16'sd1000, 1'b0, 1'b0, '0, '0, y, lat);
    e = 16'(m_step(-1000));
    n_checks++; if (y !== -16'sd1000) begin n_fail++; $display("FAIL pass_neg got=%0d exp=-1000", y); end
    for (int i = 0; i < 3; i++) begin
      x = 16'($urandom);
      xact(x, 1'b0, 1'b0, '0, '0, y, lat);
      e = 16'(m_step(int'(x)));
      n_checks++; if (y !== e) begin n_fail++; $display("FAIL pass_rand in=%0d got=%0d exp=%0d", x, y, e); end
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] y, e;
    int lat;
    cfg_write(5'd0, 16'sd32767);
    m_coef[0] = 32767;
    xact(16'sd20000, 1'b0, 1'b0, '0, '0, y, lat);
    e = 16'(m_step(20000));
    n_checks++; if (y !== 16'sd32767) begin n_fail++; $display("FAIL sat_pos got=%0d exp=32767", y); end
    n_checks++; if (y !== e) begin n_fail++; $display("FAIL sat_pos_model got=%0d exp=%0d", y, e); end
    xact(-16'sd20000, 1'b0, 1'b0, '0, '0, y, lat);
    e = 16'(m_step(-20000));
    n_checks++; if (y !== -16'sd32768) begin n_fail++; $display("FAIL sat_neg got=%0d exp=-32768", y); end
    cfg_write(5'd0, 16'sd16384);
    m_coef[0] = 16384;
  endtask

  task automatic test_recursion();
    logic signed [15:0] y;
    int lat, e;
    int ins [4] = '{16384, 0, 0, 0};
    int exps [4] = '{16384, 8192, 4096, 2048};
    clear_hist();
    cfg_write(5'd3, -16'sd8192);
    m_coef[3] = -8192;
    for (int i = 0; i < 4; i++) begin
      xact(16'(ins[i]), 1'b0, 1'b0, '0, '0, y, lat);
      e = m_step(ins[i]);
      n_checks++; if (y !== 16'(exps[i])) begin n_fail++; $display("FAIL recursion_%0d got=%0d exp=%0d", i, y, exps[i]); end
    end
  endtask

  task automatic test_clr_hist();
    logic signed [15:0] y;
    int lat, e;
    clear_hist();
    xact(16'sd0, 1'b0, 1'b0, '0, '0, y, lat);
    e = m_step(0);
    n_checks++; if (y !== 16'sd0) begin n_fail++; $display("FAIL clr_idle got=%0d exp=0", y); end
    xact(16'sd16384, 1'b0, 1'b0, '0, '0, y, lat);
    e = m_step(16384);
    // clear and handshake in the same cycle: the sample sees zeroed history
    xact(16'sd0, 1'b1, 1'b0, '0, '0, y, lat);
    m_clear();
    e = m_step(0);
    n_checks++; if (y !== 16'sd0) begin n_fail++; $display("FAIL clr_with_handshake got=%0d exp=0", y); end
    cfg_write(5'd3, 16'sd0);
    m_coef[3] = 0;
  endtask

  task automatic test_backpressure();
    logic signed [15:0] y, e;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd3000; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = 16'(m_step(3000));
    for (int k = 0; k < 300; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid got=%b exp=1", out_valid); end
    n_checks++; if (out_data !== e) begin n_fail++; $display("FAIL bp_data got=%0d exp=%0d", out_data, e); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++; if (out_data !== e || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_%0d got=%0d/%b exp=%0d/1", i, out_data, out_valid, e); end
      n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_flags_%0d in_ready=%b busy=%b exp=0/1", i, in_ready, busy); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp=0/1/0", out_valid, in_ready, busy); end
    xact(-16'sd3000, 1'b0, 1'b0, '0, '0, y, lat);
    e = 16'(m_step(-3000));
    n_checks++; if (y !== e) begin n_fail++; $display("FAIL bp_next got=%0d exp=%0d", y, e); end
  endtask

  task automatic test_back_to_back();
    int hs [2];
    int n;
    int e;
    logic signed [15:0] y;
    do_reset();
    n = 0;
    y = 'x;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'sd500;
    for (int c = 0; c < 100; c++) begin
      if (in_ready) begin
        hs[n] = c;
        n++;
        e = m_step(500);
        if (n == 2) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin y = out_data; break; end
    end
    @(posedge clk); #1;
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", n); end
    else begin
      n_checks++; if (hs[1] - hs[0] !== PERIOD) begin n_fail++; $display("FAIL b2b_period got=%0d exp=%0d", hs[1] - hs[0], PERIOD); end
    end
    n_checks++; if (y !== 16'(e) || y !== 16'sd500) begin n_fail++; $display("FAIL b2b_data got=%0d exp=500", y); end
  endtask

  task automatic test_cfg_protect();
    logic signed [15:0] y, e;
    int lat;
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd777; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = 16'(m_step(777));
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'sd0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_busy_err got=%b exp=1", cfg_err); end
    @(posedge clk); #1;
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_busy_err_pulse got=%b exp=0", cfg_err); end
    @(negedge clk);
    clr_hist = 1'b1;
    @(posedge clk); #1;
    clr_hist = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL clr_busy_err got=%b exp=1", cfg_err); end
    for (int k = 0; k < 300; k++) begin
      if (out_valid) break;
      @(posedge clk); #1;
    end
    n_checks++; if (out_data !== e || out_data !== 16'sd777) begin n_fail++; $display("FAIL cfg_busy_data got=%0d exp=777", out_data); end
    @(posedge clk); #1;
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'd20; cfg_data = 16'sd5;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    n_checks++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_addr_err got=%b exp=1", cfg_err); end
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'sd16384;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_ok_no_err got=%b exp=0", cfg_err); end
    xact(16'sd777, 1'b0, 1'b0, '0, '0, y, lat);
    e = 16'(m_step(777));
    n_checks++; if (y !== e || y !== 16'sd777) begin n_fail++; $display("FAIL cfg_rerun got=%0d exp=777", y); end
  endtask

  task automatic test_random();
    logic signed [15:0] x, y, e, d;
    int lat;
    do_reset();
    for (int i = 0; i < 5*N; i++) begin
      d = 16'(int'($urandom_range(0, 16384)) - 8192);
      cfg_write(AW'(i), d);
      m_coef[i] = int'(d);
    end
    for (int i = 0; i < 10; i++) begin
      x = 16'($urandom);
      if (i == 6) begin
        d = 16'(int'($urandom_range(0, 32767)) - 16384);
        xact(x, 1'b0, 1'b1, 5'd5, d, y, lat);
        m_coef[5] = int'(d);
      end else begin
        xact(x, 1'b0, 1'b0, '0, '0, y, lat);
      end
      e = 16'(m_step(int'(x)));
      n_checks++; if (y !== e) begin n_fail++; $display("FAIL random_%0d in=%0d got=%0d exp=%0d", i, x, y, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] y;
    int lat, e;
    logic seen;
    cfg_write(5'd0, 16'sd8192);
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'sd1234; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_async out_valid=%b in_ready=%b busy=%b exp=0/1/0", out_valid, in_ready, busy); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output got=%b exp=0", seen); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
    xact(16'sd1234, 1'b0, 1'b0, '0, '0, y, lat);
    e = m_step(1234);
    n_checks++; if (y !== 16'sd1234) begin n_fail++; $display("FAIL midrst_pass got=%0d exp=1234", y); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; clr_hist = 1'b0;
    m_reset();
    test_reset();
    test_passthrough();
    test_saturation();
    test_recursion();
    test_clr_hist();
    test_backpressure();
    test_back_to_back();
    test_cfg_protect();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
